// File: rtl/blink_pkg.sv
// Shared mode encodings and widths for the button-driven LED blinker.
package blink_pkg;
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_FAST = 2'd2,
        MODE_ON   = 2'd3
    } mode_e;

    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction
endpackage

// File: rtl/blink_ctrl_if.sv
// Button-in / LED-out signal bundle between the board pins and blink_ctrl.
interface blink_ctrl_if;
    logic       btn;
    logic       led;
    logic [1:0] mode;
    logic       btn_pulse;

    modport slave  (input  btn, output led, output mode, output btn_pulse);
    modport master (output btn, input  led, input  mode, input  btn_pulse);
endinterface

// File: rtl/blink_ctrl_debounce.sv
// Two-flop synchronizer, saturating-free debounce counter and press strobe.
module btn_debounce
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BTN_ACTIVE_LOW  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pressed_pulse
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_btn_pol;
    logic             r_sync0;
    logic             r_sync1;
    logic             r_deb;
    logic             r_deb_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    assign w_btn_pol = (BTN_ACTIVE_LOW != 0) ? ~btn : btn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= w_btn_pol;
            r_sync1 <= r_sync0;
        end
    end

    // Count stays below DEB_LAST+1, so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync1 == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == DEB_LAST) begin
            r_deb <= r_sync1;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_d <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_deb_d <= r_deb;
            r_pulse <= r_deb & ~r_deb_d;
        end
    end

    assign pressed_pulse = r_pulse;
endmodule

// File: rtl/blink_ctrl.sv
// Mode FSM (OFF->SLOW->FAST->ON) advanced by debounced presses, plus the LED blink divider.
module blink_ctrl
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SLOW_DIV        = 50_000_000,
    parameter int FAST_DIV        = 12_500_000,
    parameter int BTN_ACTIVE_LOW  = 0
) (
    input  logic         clk,
    input  logic         rst,
    blink_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

    logic             w_pulse;
    logic [CNT_W-1:0] w_last;
    mode_e            w_next;
    mode_e            r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_led;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_deb (
        .clk           (clk),
        .rst           (rst),
        .btn           (bus.btn),
        .pressed_pulse (w_pulse)
    );

    assign w_next = next_mode(r_mode);
    assign w_last = (r_mode == MODE_FAST) ? FAST_LAST : SLOW_LAST;

    // A mode change wins over a terminal-count toggle on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_OFF;
            r_cnt  <= '0;
            r_led  <= 1'b0;
        end else if (w_pulse) begin
            r_mode <= w_next;
            r_cnt  <= '0;
            r_led  <= (w_next == MODE_ON);
        end else begin
            case (r_mode)
                MODE_OFF: begin
                    r_cnt <= '0;
                    r_led <= 1'b0;
                end
                MODE_ON: begin
                    r_cnt <= '0;
                    r_led <= 1'b1;
                end
                default: begin
                    if (r_cnt == w_last) begin
                        r_cnt <= '0;
                        r_led <= ~r_led;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.led       = r_led;
    assign bus.mode      = r_mode;
    assign bus.btn_pulse = w_pulse;
endmodule

// File: tb/tb_blink_ctrl.sv
// Directed bench for blink_ctrl with short debounce and divider settings.
module tb_blink_ctrl;
    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    blink_ctrl_if bif ();

    blink_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .SLOW_DIV        (8),
        .FAST_DIV        (2),
        .BTN_ACTIVE_LOW  (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk3(input string tag, input logic [1:0] m, input logic l, input logic p);
        chk({tag, "_mode"}, 32'(bif.mode), 32'(m));
        chk({tag, "_led"}, 32'(bif.led), 32'(l));
        chk({tag, "_pulse"}, 32'(bif.btn_pulse), 32'(p));
    endtask

    initial begin
        rst = 1'b1;
        bif.btn = 1'b0;
        #3;
        chk3("rst0", 2'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 50; i++) begin
            tick();
            chk3("idle", 2'd0, 1'b0, 1'b0);
        end

        // bouncy press; final rising edge is the last assignment
        bif.btn = 1'b1; tick();
        bif.btn = 1'b0; tick();
        bif.btn = 1'b1; tick();
        bif.btn = 1'b0; tick();
        chk("bounce_nopulse", 32'(bif.btn_pulse), 32'd0);
        bif.btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("bnc_pulse", 32'(bif.btn_pulse), (i == 7) ? 32'd1 : 32'd0);
            chk("bnc_mode", 32'(bif.mode), (i == 8) ? 32'd1 : 32'd0);
        end

        // SLOW blinking, release at k=10, re-press at k=62 so mode changes with counter=5
        for (int k = 1; k <= 69; k++) begin
            tick();
            chk("slow_led", 32'(bif.led), 32'((k / 8) % 2));
            chk("slow_mode", 32'(bif.mode), 32'd1);
            chk("slow_pulse", 32'(bif.btn_pulse), (k == 69) ? 32'd1 : 32'd0);
            if (k == 10) bif.btn = 1'b0;
            if (k == 62) bif.btn = 1'b1;
        end
        tick();
        chk3("to_fast", 2'd2, 1'b0, 1'b0);

        // FAST blinking
        for (int j = 1; j <= 16; j++) begin
            tick();
            chk("fast_led", 32'(bif.led), 32'((j / 2) % 2));
            chk("fast_mode", 32'(bif.mode), 32'd2);
            chk("fast_pulse", 32'(bif.btn_pulse), 32'd0);
            if (j == 1) bif.btn = 1'b0;
        end

        // press -> ON
        bif.btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("on_pulse", 32'(bif.btn_pulse), (i == 7) ? 32'd1 : 32'd0);
            chk("on_mode", 32'(bif.mode), (i == 8) ? 32'd3 : 32'd2);
            if (i == 8) chk("on_led", 32'(bif.led), 32'd1);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            chk3("hold", 2'd3, 1'b1, 1'b0);
        end
        bif.btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk3("rel_on", 2'd3, 1'b1, 1'b0);
        end

        // press -> OFF (wrap)
        bif.btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("off_pulse", 32'(bif.btn_pulse), (i == 7) ? 32'd1 : 32'd0);
            chk("off_mode", 32'(bif.mode), (i == 8) ? 32'd0 : 32'd3);
            chk("off_led", 32'(bif.led), (i == 8) ? 32'd0 : 32'd1);
        end
        bif.btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk3("rel_off", 2'd0, 1'b0, 1'b0);
        end

        // glitch rejection: 3-cycle highs never reach the 4-cycle threshold
        for (int r = 0; r < 10; r++) begin
            bif.btn = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("glitch_hi", 32'(bif.btn_pulse), 32'd0);
            end
            bif.btn = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("glitch_lo", 32'(bif.btn_pulse), 32'd0);
            end
        end
        for (int i = 0; i < 5; i++) tick();
        chk3("glitch_end", 2'd0, 1'b0, 1'b0);

        // async reset mid-blink with the button still held
        bif.btn = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 8) chk("pre_rst_mode", 32'(bif.mode), 32'd1);
            if (i == 18) chk("pre_rst_led", 32'(bif.led), 32'd1);
        end
        #2;
        rst = 1'b1;
        #1;
        chk3("async_rst", 2'd0, 1'b0, 1'b0);
        tick();
        chk3("rst_hold", 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("post_rst_pulse", 32'(bif.btn_pulse), (i == 7) ? 32'd1 : 32'd0);
            chk("post_rst_mode", 32'(bif.mode), (i == 8) ? 32'd1 : 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
